rx_frame_collector: RTL
=======================

// Module: rx_frame_collector
// PURPOSE
// Egress end of the VOQ ring: consumes words whose destination field equals NUB, sorts them into per-source FIFOs,
// and replays whole frames, one source at a time, to the output port over a valid/ready stream.
// Frames arrive word-interleaved across sources; each leaves contiguously, with the source chosen round-robin.
// PARAMETERS
// NUB         0                      destination port served by this instance
// PORT_NUB    `PORT_NUB_TOTAL        number of source ports; WIDTH_SEL = $clog2(PORT_NUB)
// FIFO_DEPTH  8                      words per source FIFO, power of two >= 4
// Derived: WIDTH_DATA=`DATA_WIDTH, WIDTH_PORT=WIDTH_SEL+WIDTH_DATA, WIDTH_LENGTH=$clog2(`DATA_LENGTH_MAX)
// PORTS
// clk        in   1            clock
// rst_n      in   1            asynchronous active-low reset
// valid_in   in   1            ring word valid
// nub_in     in   WIDTH_SEL    source port of ring word
// data_in    in   WIDTH_PORT   {dst[WIDTH_SEL], payload[WIDTH_DATA]}
// keep_out   out  1            registered ring backpressure
// m_valid    out  1            egress word valid
// m_ready    in   1            egress accepts word
// m_data     out  WIDTH_DATA   egress payload
// m_src      out  WIDTH_SEL    source of current frame
// m_sof      out  1            first (header) word of frame
// m_eof      out  1            last word of frame
// frame_done out  1            one-cycle pulse after eof handshake
// ovf_cnt    out  16           dropped-word count (RX_OVF_CNT_EN only)
// BEHAVIOUR
// - Reset: all FIFOs empty, state IDLE, rr_ptr=0, len_cnt=0, keep_out=0, frame_done=0, ovf_cnt=0.
// - Accept: valid_in && data_in[WIDTH_PORT-1 -: WIDTH_SEL]==NUB -> push payload into FIFO[nub_in] in the same
//   edge. Words for other destinations are ignored. A push to a full FIFO is dropped; FIFO state is unchanged.
// - keep_out: registered. Next value is 1 iff any FIFO has <=2 free entries after this cycle's push/pop.
// - Frame format: word0 = header, carrying LEN in [WIDTH_LENGTH+`CRC32_LENGTH+WIDTH_PRIORITY-1 : `CRC32_LENGTH+WIDTH_PRIORITY].
//   The frame has LEN further words (total LEN+1).
// - FSM:
//   IDLE: scan sources rr_ptr, rr_ptr+1, ... (mod PORT_NUB). Latch the first non-empty as sel and go to HEAD.
//         If all FIFOs are empty, stay in IDLE.
//   HEAD: m_valid = !empty[sel], m_sof=1. On handshake: pop; len_cnt <= LEN.
//         LEN==0 -> m_eof=1 on this word, go to DONE. Otherwise go to BODY.
//   BODY: m_valid = !empty[sel]; m_eof = (len_cnt==1). On handshake: pop, len_cnt-1.
//         If len_cnt==1, go to DONE. An empty FIFO stalls in BODY; no other source is served mid-frame.
//   DONE: frame_done=1 for one cycle; rr_ptr <= sel+1 (wraps at PORT_NUB-1 -> 0); go to IDLE.
// - m_data/m_src/m_sof/m_eof are combinational from FIFO[sel] head and state, valid only while m_valid=1.
//   Latency from push to m_valid is >= 2 cycles (IDLE scan + HEAD).
// - A push and a pop to the same FIFO in one cycle are both performed, including when the FIFO is full
//   (the pop frees a slot first). Count arithmetic is modulo FIFO_DEPTH with a separate full/empty bit.
// - m_ready may be held high continuously; the full rate is 1 word/cycle in HEAD/BODY.
// - Reset mid-frame discards all buffered words. There is no partial-frame recovery.
// CONFIGURATION
// - `define RX_OVF_CNT_EN: adds port ovf_cnt. It increments by 1 per dropped word and saturates at 16'hFFFF.
// - Without the macro: the port is absent and drops are silent. All other behaviour is identical.
// TESTING
// T1 single frame: src 2, header LEN=3 + 3 words, m_ready=1 -> 4 beats, sof on beat0, eof on beat3,
//    m_src=2, frame_done one cycle after eof.
// T2 interleave: src0 and src1 frames (LEN=2) interleaved word-by-word, rr_ptr=0 -> src0 frame fully,
//    then src1 frame fully, no mixing.
// T3 backpressure: m_ready toggles 1010..., LEN=4 -> data order preserved, no pop on m_ready=0,
//    eof after exactly 5 handshakes.
// T4 overflow: FIFO_DEPTH=8, push 10 words to src3 with m_ready=0 -> keep_out=1 once <=2 free,
//    2 words dropped, ovf_cnt=2 (EN).
// T5 wrap/LEN=0: header-only frames from src PORT_NUB-1 then src 0 -> each 1 beat with sof=eof=1;
//    rr_ptr wraps to 0 and src0 is served next.
// T6 reset mid-frame: assert rst_n low during BODY -> all outputs go to reset values; next frame is served cleanly.

Source files
------------

// File: rtl/rx_frame_collector_if.sv
// rx_frame_collector_if
// Egress stream between the frame collector and the output port. It is a
// valid/ready stream that carries one payload word per beat, together with
// the frame's source and its start/end markers.
//
// Signals
//   m_valid  collector -> port  beat valid
//   m_ready  port -> collector  port accepts the beat
//   m_data   collector -> port  payload word
//   m_src    collector -> port  source port of the frame in flight
//   m_sof    collector -> port  first (header) word of the frame
//   m_eof    collector -> port  last word of the frame
//
// Modports
//   master  the side that produces the stream (the collector)
//   slave   the side that consumes the stream (the output port)

interface rx_frame_collector_if #(
    parameter int WIDTH_DATA = 64,
    parameter int WIDTH_SEL  = 2
);

    logic                  m_valid;
    logic                  m_ready;
    logic [WIDTH_DATA-1:0] m_data;
    logic [WIDTH_SEL-1:0]  m_src;
    logic                  m_sof;
    logic                  m_eof;

    modport master (
        output m_valid,
        output m_data,
        output m_src,
        output m_sof,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_src,
        input  m_sof,
        input  m_eof,
        output m_ready
    );

endinterface

// File: rtl/rx_frame_collector.sv
// rx_frame_collector
// This block is the egress end of the VOQ ring. It takes every ring word
// whose destination field equals NUB and pushes the payload into a FIFO
// that belongs to the word's source. It then replays whole frames, one
// source at a time, onto a valid/ready stream. Frames can arrive
// interleaved word by word across sources. Each frame leaves as one
// contiguous run, and the next source is chosen round-robin.
//
// Frame format: word 0 is the header. It carries LEN in
// [WIDTH_LENGTH+CRC32_LENGTH+WIDTH_PRIORITY-1 : CRC32_LENGTH+WIDTH_PRIORITY],
// and LEN further words follow it.
//
// Ports
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   valid_in    in   ring word valid
//   nub_in      in   source port of the ring word
//   data_in     in   {dst[WIDTH_SEL], payload[WIDTH_DATA]}
//   keep_out    out  registered ring backpressure: some FIFO has <=2 free
//   m_if        --   egress stream (master modport of rx_frame_collector_if)
//   frame_done  out  one-cycle pulse after the eof handshake
//   ovf_cnt     out  saturating count of dropped words (RX_OVF_CNT_EN only)
//
// Configuration
//   RX_OVF_CNT_EN  When defined, the ovf_cnt port is added. Without it,
//                  words pushed to a full FIFO are dropped silently.
//
// Defaults for the codebase-wide macros are supplied below in case the
// project header is not included ahead of this file.

`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 256
`endif
`ifndef CRC32_LENGTH
`define CRC32_LENGTH 32
`endif

module rx_frame_collector #(
    parameter int NUB            = 0,
    parameter int PORT_NUB       = `PORT_NUB_TOTAL,
    parameter int FIFO_DEPTH     = 8,
    parameter int WIDTH_PRIORITY = 3,
    localparam int WIDTH_SEL     = $clog2(PORT_NUB),
    localparam int WIDTH_DATA    = `DATA_WIDTH,
    localparam int WIDTH_PORT    = WIDTH_SEL + WIDTH_DATA,
    localparam int WIDTH_LENGTH  = $clog2(`DATA_LENGTH_MAX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [WIDTH_SEL-1:0]  nub_in,
    input  logic [WIDTH_PORT-1:0] data_in,
    output logic                  keep_out,
    rx_frame_collector_if.master  m_if,
    output logic                  frame_done
`ifdef RX_OVF_CNT_EN
   ,output logic [15:0]           ovf_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int LEN_LSB = `CRC32_LENGTH + WIDTH_PRIORITY;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY,
        DONE
    } state_t;

    // Frame sequencer state
    state_t                  state;
    logic [WIDTH_SEL-1:0]    sel;
    logic [WIDTH_SEL-1:0]    rr_ptr;
    logic [WIDTH_LENGTH-1:0] len_cnt;

    // Per-source FIFOs. The count wraps modulo FIFO_DEPTH, and a separate
    // full bit tells a full FIFO apart from an empty one.
    logic [WIDTH_DATA-1:0]   fifo_mem [PORT_NUB][FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr   [PORT_NUB];
    logic [PTR_W-1:0]        rd_ptr   [PORT_NUB];
    logic [PTR_W-1:0]        fifo_cnt [PORT_NUB];
    logic [PORT_NUB-1:0]     fifo_full;
    logic [PORT_NUB-1:0]     fifo_empty;
    logic [OCC_W-1:0]        occ_cur  [PORT_NUB];
    logic [OCC_W-1:0]        occ_next [PORT_NUB];

    logic [PORT_NUB-1:0]     push_req;
    logic [PORT_NUB-1:0]     push_ok;
    logic [PORT_NUB-1:0]     pop;

    logic                    accept;
    logic [WIDTH_DATA-1:0]   payload;
    logic [WIDTH_DATA-1:0]   head_data;
    logic [WIDTH_LENGTH-1:0] hdr_len;
    logic                    out_fire;
    logic                    keep_next;
    logic                    scan_hit;
    logic [WIDTH_SEL-1:0]    scan_sel;
    logic [WIDTH_SEL-1:0]    sel_inc;

    // ------------------------------------------------------------------
    // Ring intake
    // ------------------------------------------------------------------
    assign accept  = valid_in && (data_in[WIDTH_PORT-1 -: WIDTH_SEL] == WIDTH_SEL'(NUB));
    assign payload = data_in[WIDTH_DATA-1:0];

    // ------------------------------------------------------------------
    // FIFO status taken from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < PORT_NUB; i++) begin
            fifo_empty[i] = !fifo_full[i] && (fifo_cnt[i] == '0);
            occ_cur[i]    = fifo_full[i] ? OCC_W'(FIFO_DEPTH) : {1'b0, fifo_cnt[i]};
        end
    end

    // ------------------------------------------------------------------
    // Egress stream: driven combinationally from the head of FIFO[sel]
    // and from the current state.
    // ------------------------------------------------------------------
    assign head_data = fifo_mem[sel][rd_ptr[sel]];
    assign hdr_len   = head_data[LEN_LSB +: WIDTH_LENGTH];

    // NOTE: every output of a combinational block gets a default before the case, otherwise a missed branch infers a latch.
    always_comb begin
        m_if.m_valid = 1'b0;
        m_if.m_eof   = 1'b0;
        unique case (state)
            HEAD: begin
                m_if.m_valid = !fifo_empty[sel];
                m_if.m_eof   = (hdr_len == '0);
            end
            BODY: begin
                m_if.m_valid = !fifo_empty[sel];
                m_if.m_eof   = (len_cnt == WIDTH_LENGTH'(1));
            end
            default: ;
        endcase
    end

    assign m_if.m_data = head_data;
    assign m_if.m_src  = sel;
    assign m_if.m_sof  = (state == HEAD);
    assign out_fire    = m_if.m_valid && m_if.m_ready;

    // ------------------------------------------------------------------
    // Push/pop decode and next occupancy. When a FIFO is full, a push is
    // still accepted if the same FIFO is popped in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        keep_next = 1'b0;
        for (int i = 0; i < PORT_NUB; i++) begin
            push_req[i] = accept && (nub_in == WIDTH_SEL'(i));
            pop[i]      = out_fire && (sel == WIDTH_SEL'(i));
            push_ok[i]  = push_req[i] && (!fifo_full[i] || pop[i]);
            occ_next[i] = occ_cur[i] + OCC_W'(push_ok[i]) - OCC_W'(pop[i]);
            if (occ_next[i] >= OCC_W'(FIFO_DEPTH - 2)) begin
                keep_next = 1'b1;
            end
        end
    end

    // NOTE: sequential state is assigned with <= so that every register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORT_NUB; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                fifo_cnt[i] <= '0;
            end
            fifo_full <= '0;
            keep_out  <= 1'b0;
        end else begin
            for (int i = 0; i < PORT_NUB; i++) begin
                if (push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                fifo_cnt[i]  <= occ_next[i][PTR_W-1:0];
                fifo_full[i] <= occ_next[i][PTR_W];
            end
            keep_out <= keep_next;
        end
    end

    // NOTE: the storage array has no reset; the pointers and flags alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_NUB; i++) begin
            if (push_ok[i]) begin
                fifo_mem[i][wr_ptr[i]] <= payload;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin scan. The loop walks the offsets from the farthest to the
    // nearest, so the closest non-empty source after rr_ptr is the last
    // match written and wins.
    // ------------------------------------------------------------------
    always_comb begin
        int                   idx;
        logic [WIDTH_SEL-1:0] idx_sel;
        scan_hit = 1'b0;
        scan_sel = rr_ptr;
        idx      = 0;
        idx_sel  = '0;
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= PORT_NUB) begin
                idx = idx - PORT_NUB;
            end
            idx_sel = WIDTH_SEL'(idx);
            if (!fifo_empty[idx_sel]) begin
                scan_hit = 1'b1;
                scan_sel = idx_sel;
            end
        end
    end

    assign sel_inc = (sel == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : sel + WIDTH_SEL'(1);

    // ------------------------------------------------------------------
    // Frame sequencer. Once a source is selected, it is held until its
    // frame completes. An empty FIFO in the middle of a frame stalls the
    // stream and does not hand the port to another source.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
            len_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scan_hit) begin
                        sel   <= scan_sel;
                        state <= HEAD;
                    end
                end
                HEAD: begin
                    if (out_fire) begin
                        len_cnt <= hdr_len;
                        if (hdr_len == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (out_fire) begin
                        len_cnt <= len_cnt - WIDTH_LENGTH'(1);
                        if (len_cnt == WIDTH_LENGTH'(1)) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    rr_ptr <= sel_inc;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RX_OVF_CNT_EN
    // ------------------------------------------------------------------
    // Drop counter. At most one word arrives per cycle, so at most one drop
    // can occur per cycle. The counter saturates rather than wrapping.
    // ------------------------------------------------------------------
    logic drop;
    assign drop = |(push_req & ~push_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule
